err_comp_acc: RTL and testbench

ERR_COMP_ACC -- requirements
Module: err_comp_acc

---
 rtl/err_comp_acc.sv | 88 ++++++++
 tb/tb_err_comp_acc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/err_comp_acc.sv
// Error-compensation accumulator: sums signed rounded error products per dot product
// with saturation, then holds the result until the MAC correction stage consumes it.
module err_comp_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic signed [15:0]      rounded_error_product,
  output logic                    comp_valid,
  input  logic                    comp_ready,
  output logic signed [ACC_W-1:0] comp_sum,
  output logic [CNT_W-1:0]        comp_count,
  output logic                    comp_sat
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     sat, sat_nxt;
  logic                     accept;
  logic signed [ACC_W:0]    sum_wide;

  assign in_ready   = (state != HOLD);
  assign comp_valid = (state == HOLD);
  assign comp_sum   = acc;
  assign comp_count = cnt;
  assign comp_sat   = sat;
  assign accept     = in_valid && in_ready;

  // One guard bit above ACC_W: overflow shows as the top two bits disagreeing.
  assign sum_wide = {acc[ACC_W-1], acc}
                  + {{(ACC_W+1-16){rounded_error_product[15]}}, rounded_error_product};

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sat_nxt   = sat;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            acc_nxt = sum_wide[ACC_W] ? SUM_MIN : SUM_MAX;
            sat_nxt = 1'b1;
          end else begin
            acc_nxt = sum_wide[ACC_W-1:0];
          end
          if (&cnt) sat_nxt = 1'b1;
          else      cnt_nxt = cnt + 1'b1;
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (comp_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          sat_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_err_comp_acc.sv
// Bench for err_comp_acc: three parameterisations share one stimulus stream and are
// checked against a saturating-arithmetic reference model plus directed vector tables.
module tb_err_comp_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, comp_ready;
  logic [15:0] prod;

  logic               r0, r1, r2, v0, v1, v2, t0, t1, t2;
  logic signed [23:0] s0;
  logic signed [16:0] s1;
  logic signed [23:0] s2;
  logic [7:0]         c0, c1;
  logic [1:0]         c2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  err_comp_acc #(.ACC_W(24), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .in_last(in_last),
    .rounded_error_product(prod), .comp_valid(v0), .comp_ready(comp_ready),
    .comp_sum(s0), .comp_count(c0), .comp_sat(t0));

  err_comp_acc #(.ACC_W(17), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .in_last(in_last),
    .rounded_error_product(prod), .comp_valid(v1), .comp_ready(comp_ready),
    .comp_sum(s1), .comp_count(c1), .comp_sat(t1));

  err_comp_acc #(.ACC_W(24), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2), .in_last(in_last),
    .rounded_error_product(prod), .comp_valid(v2), .comp_ready(comp_ready),
    .comp_sum(s2), .comp_count(c2), .comp_sat(t2));

  // Reference model: per-instance saturating sum, term count, sticky flag; one shared
  // "result pending" flag since handshake behaviour does not depend on widths.
  int     aw [3] = '{24, 17, 24};
  int     cw [3] = '{8, 8, 2};
  longint m_sum [3];
  int     m_cnt [3];
  bit     m_sat [3];
  bit     m_hold;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
    end
    m_hold = 0;
  endtask

  task automatic model_edge();
    longint s, lim;
    if (m_hold) begin
      if (comp_ready) model_clear();
    end else if (in_valid) begin
      for (int i = 0; i < 3; i++) begin
        lim = (longint'(1) << (aw[i] - 1)) - 1;
        s = m_sum[i] + longint'($signed(prod));
        if (s > lim)        begin s = lim;      m_sat[i] = 1; end
        else if (s < -lim-1) begin s = -lim - 1; m_sat[i] = 1; end
        m_sum[i] = s;
        if (m_cnt[i] == (1 << cw[i]) - 1) m_sat[i] = 1;
        else                             m_cnt[i]++;
      end
      if (in_last) m_hold = 1;
    end
  endtask

  task automatic cmp(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint act_sum(input int i);
    case (i)
      0: return longint'(s0);
      1: return longint'(s1);
      default: return longint'(s2);
    endcase
  endfunction

  function automatic longint act_cnt(input int i);
    case (i)
      0: return longint'(c0);
      1: return longint'(c1);
      default: return longint'(c2);
    endcase
  endfunction

  function automatic bit act_bit(input int i, input int which);
    logic [2:0] vv, rr, tt;
    vv = {v2, v1, v0}; rr = {r2, r1, r0}; tt = {t2, t1, t0};
    case (which)
      0: return vv[i];
      1: return rr[i];
      default: return tt[i];
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("%s dut%0d valid", tag, i), act_bit(i, 0), m_hold);
      cmp($sformatf("%s dut%0d ready", tag, i), act_bit(i, 1), !m_hold);
      cmp($sformatf("%s dut%0d sum",   tag, i), act_sum(i), m_sum[i]);
      cmp($sformatf("%s dut%0d count", tag, i), act_cnt(i), m_cnt[i]);
      cmp($sformatf("%s dut%0d sat",   tag, i), act_bit(i, 2), m_sat[i]);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit l, input logic [15:0] p, input bit r);
    in_valid = v; in_last = l; prod = p; comp_ready = r;
  endtask

  typedef struct {
    bit          v, l;
    logic [15:0] p;
    bit          r;
    int          sel;
    bit          ev;
    longint      es;
    int          ec;
    bit          esat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int      bubbles;
    longint  res[$];
    logic [15:0] q[$];
    bit      lastq[$];
    bit      acc_now;

    // Directed vectors: three-term sum, 17-bit clamp, 2-bit counter saturation.
    tbl.push_back(vec_t'{1, 0, 16'h0004, 1, 0, 0, 4, 1, 0});
    tbl.push_back(vec_t'{1, 0, 16'hFFF8, 1, 0, 0, -4, 2, 0});
    tbl.push_back(vec_t'{1, 1, 16'h0010, 1, 0, 1, 12, 3, 0});
    tbl.push_back(vec_t'{0, 0, 16'h0000, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 0, 16'h7FFC, 1, 1, 0, 32764, 1, 0});
    tbl.push_back(vec_t'{1, 0, 16'h7FFC, 1, 1, 0, 65528, 2, 0});
    tbl.push_back(vec_t'{1, 0, 16'h7FFC, 1, 1, 0, 65535, 3, 1});
    tbl.push_back(vec_t'{1, 1, 16'h7FFC, 1, 1, 1, 65535, 4, 1});
    tbl.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 0, 16'h0001, 1, 2, 0, 1, 1, 0});
    tbl.push_back(vec_t'{1, 0, 16'h0001, 1, 2, 0, 2, 2, 0});
    tbl.push_back(vec_t'{1, 0, 16'h0001, 1, 2, 0, 3, 3, 0});
    tbl.push_back(vec_t'{1, 0, 16'h0001, 1, 2, 0, 4, 3, 1});
    tbl.push_back(vec_t'{1, 1, 16'h0001, 1, 2, 1, 5, 3, 1});
    tbl.push_back(vec_t'{0, 0, 16'h0000, 1, 2, 0, 0, 0, 0});

    rst_n = 1'b0;
    drive(0, 0, 16'h0000, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].l, tbl[k].p, tbl[k].r);
      step($sformatf("vec%0d", k));
      cmp($sformatf("vec%0d valid", k), act_bit(tbl[k].sel, 0), tbl[k].ev);
      cmp($sformatf("vec%0d sum",   k), act_sum(tbl[k].sel), tbl[k].es);
      cmp($sformatf("vec%0d count", k), act_cnt(tbl[k].sel), tbl[k].ec);
      cmp($sformatf("vec%0d sat",   k), act_bit(tbl[k].sel, 2), tbl[k].esat);
    end

    // Result held with back-pressure while upstream keeps offering a term.
    drive(1, 1, 16'h0003, 0);
    step("hold_fill");
    drive(1, 0, 16'h0100, 0);
    for (int k = 0; k < 5; k++) begin
      step("hold_wait");
      cmp("hold in_ready", r0, 0);
      cmp("hold sum stable", s0, 3);
    end
    comp_ready = 1'b1;
    step("hold_release");
    cmp("release valid", v0, 0);
    cmp("release sum", s0, 0);
    comp_ready = 1'b0;
    step("hold_next_accept");
    cmp("next accept sum", s0, 256);
    cmp("next accept count", c0, 1);
    drive(1, 1, 16'h0000, 0);
    step("hold_close");
    drive(0, 0, 16'h0000, 1);
    step("hold_drain");

    // Asynchronous reset mid-ACCUM discards the partial sum.
    drive(1, 0, 16'h0005, 0);
    step("rst_acc1");
    step("rst_acc2");
    #2 rst_n = 1'b0;
    drive(0, 0, 16'h0000, 0);
    model_clear();
    #1 check_all("rst_async");
    repeat (2) @(posedge clk);
    #1 cmp("rst held valid", v0, 0);
    @(negedge clk) rst_n = 1'b1;
    drive(1, 1, 16'h0008, 0);
    step("rst_single");
    cmp("single sum", s0, 8);
    cmp("single count", c0, 1);
    drive(0, 0, 16'h0000, 1);
    step("rst_drain");

    // Back-to-back dot products with comp_ready tied high.
    q = '{16'h0001, 16'h0002, 16'h0003, 16'h000A, 16'h0014};
    lastq = '{0, 0, 1, 0, 1};
    bubbles = 0;
    comp_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      in_valid = 1'b1; prod = q[0]; in_last = lastq[0];
      acc_now = r0;
      step("b2b");
      if (acc_now) begin
        void'(q.pop_front()); void'(lastq.pop_front());
      end else bubbles++;
      if (v0) res.push_back(longint'(s0));
    end
    cmp("b2b all terms accepted", q.size(), 0);
    cmp("b2b bubbles", bubbles, 1);
    cmp("b2b results", res.size(), 2);
    if (res.size() == 2) begin
      cmp("b2b sum A", res[0], 6);
      cmp("b2b sum B", res[1], 30);
    end
    drive(0, 0, 16'h0000, 1);
    step("b2b_drain");

    // Randomized traffic, extremes weighted to exercise clamping.
    for (int k = 0; k < 400; k++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_last    = ($urandom_range(0, 7) == 0);
      comp_ready = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: prod = 16'h7FFF;
        1: prod = 16'h8000;
        default: prod = 16'($urandom);
      endcase
      step("rand");
    end
    drive(0, 0, 16'h0000, 1);
    step("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
